// File: rtl/switch_allocator_rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_allocator_rr_pkg
//  Description : Shared configuration for the N x M packet switch and its
//                round-robin allocator. Holds the port counts, the destination
//                field width, the select-matrix type shared by the allocator
//                and the switch, and a small pointer helper.
//                Build-time sizes come from the `N / `M macros (default 5).
//  Revision    : 1.0  initial release
// ============================================================================

`ifndef N
`define N 5
`endif
`ifndef M
`define M 5
`endif

package switch_allocator_rr_pkg;

    localparam int SA_N  = `N;
    localparam int SA_M  = `M;
    localparam int SA_DW = (SA_M > 1) ? $clog2(SA_M) : 1;

    // o_sel[m][j] = 1 : input j drives output m (element 0 is the MSB).
    typedef logic [0:SA_M-1][0:SA_N-1] sel_t;

    // Round-robin successor of idx in 0..n-1; index n-1 wraps to 0.
    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/switch_allocator_rr_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Single-output round-robin picker. Grants the first asserted
//                request at index i_ptr, i_ptr+1, ... modulo N.
//  Ports       : i_req [0:N-1]  request vector (element 0 is the MSB)
//                i_ptr [PW-1:0] highest-priority index this cycle
//                i_en           grant allowed (output ready, not in reset)
//                o_gnt [0:N-1]  one-hot grant or all zero
//  Revision    : 1.0  initial release
// ============================================================================

module rr_arbiter #(
    parameter int N  = 5,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [0:N-1]  i_req,
    input  logic [PW-1:0] i_ptr,
    input  logic          i_en,
    output logic [0:N-1]  o_gnt
);

    logic w_found;

    // Offset k walks the ring starting at the pointer; for each k exactly one
    // j matches, so the first hit in k order is the round-robin winner.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (i_en && !w_found && i_req[j] &&
                    (((int'(i_ptr) + k) % N) == j)) begin
                    o_gnt[j] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/switch_allocator_rr.sv
`default_nettype none
// ============================================================================
//  Module      : switch_allocator_rr
//  Description : Per-output round-robin allocator for the N x M switch.
//                Each output arbitrates independently; the grant path is
//                purely combinational, lock/owner/pointer state updates on
//                the following clock edge.
//                Optional feature macro: SWITCH_ALLOC_LOCK_EN
//                  defined     -> wormhole locking from head to tail flit
//                  not defined -> every flit arbitrates on its own, i_tail
//                                 is ignored
//  Ports       : clk, reset (synchronous, active-high)
//                i_req   [0:N-1]           input j holds a flit
//                i_dest  [0:N-1][DW-1:0]   requested output (>= M: no request)
//                i_tail  [0:N-1]           last flit of the packet
//                i_ready [0:M-1]           output m accepts a flit
//                o_sel   [0:M-1][0:N-1]    one-hot select per output
//                o_grant [0:N-1]           input j's flit crosses this cycle
//  Revision    : 1.0  initial release
// ============================================================================

`ifndef N
`define N 5
`endif
`ifndef M
`define M 5
`endif

module switch_allocator_rr
    import switch_allocator_rr_pkg::*;
#(
    parameter int N  = `N,
    parameter int M  = `M,
    parameter int DW = (M > 1) ? $clog2(M) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [0:N-1]           i_req,
    input  logic [0:N-1][DW-1:0]   i_dest,
    input  logic [0:N-1]           i_tail,
    input  logic [0:M-1]           i_ready,
    output logic [0:M-1][0:N-1]    o_sel,
    output logic [0:N-1]           o_grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [0:M-1][PW-1:0] ptr_q, ptr_d;
    logic [0:M-1][0:N-1]  w_elig;
    logic [0:M-1][0:N-1]  w_gnt;

`ifdef SWITCH_ALLOC_LOCK_EN
    logic [0:M-1]         lock_q, lock_d;
    logic [0:M-1][PW-1:0] owner_q, owner_d;
`else
    logic                 w_unused_tail;
    assign w_unused_tail = ^i_tail;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
`ifdef SWITCH_ALLOC_LOCK_EN
            lock_q  <= '0;
            owner_q <= '0;
`endif
        end else begin
            ptr_q   <= ptr_d;
`ifdef SWITCH_ALLOC_LOCK_EN
            lock_q  <= lock_d;
            owner_q <= owner_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state: a grant advances the pointer past the winner and, with
    // locking, holds the output for the winner until its tail flit.
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d   = ptr_q;
`ifdef SWITCH_ALLOC_LOCK_EN
        lock_d  = lock_q;
        owner_d = owner_q;
`endif
        for (int m = 0; m < M; m++) begin
            for (int j = 0; j < N; j++) begin
                if (w_gnt[m][j]) begin
                    ptr_d[m]   = PW'(rr_next(j, N));
`ifdef SWITCH_ALLOC_LOCK_EN
                    lock_d[m]  = ~i_tail[j];
                    owner_d[m] = PW'(j);
`endif
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: eligibility per output, then one arbiter per output.
    // A locked output masks every requester except its owner, so the
    // arbiter can only pick the owner regardless of the pointer.
    // ------------------------------------------------------------------
    always_comb begin
        w_elig = '0;
        for (int m = 0; m < M; m++) begin
            for (int j = 0; j < N; j++) begin
                w_elig[m][j] = i_req[j] && (i_dest[j] == DW'(m));
`ifdef SWITCH_ALLOC_LOCK_EN
                if (lock_q[m] && (owner_q[m] != PW'(j))) begin
                    w_elig[m][j] = 1'b0;
                end
`endif
            end
        end
    end

    for (genvar m = 0; m < M; m++) begin : g_arb
        rr_arbiter #(
            .N  (N),
            .PW (PW)
        ) u_arb (
            .i_req (w_elig[m]),
            .i_ptr (ptr_q[m]),
            .i_en  (i_ready[m] & ~reset),
            .o_gnt (w_gnt[m])
        );
    end

    assign o_sel = w_gnt;

    always_comb begin
        o_grant = '0;
        for (int m = 0; m < M; m++) begin
            o_grant = o_grant | w_gnt[m];
        end
    end

endmodule

`default_nettype wire
